// File: rtl/mult_pkg.sv
// Shared widths and reset value for the 4x4 array multiplier.
package mult_pkg;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;
  localparam logic [PROD_W-1:0] PROD_RST = 8'h00;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used in the reduction array.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/multiplier_4x4.sv
// Unsigned 4x4 AND/adder array multiplier with a registered 8-bit product.
module multiplier_4x4
  import mult_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic p0,
  output logic p1,
  output logic p2,
  output logic p3,
  output logic p4,
  output logic p5,
  output logic p6,
  output logic p7
);
  logic [OP_W-1:0] a_vec, b_vec;
  logic [OP_W-1:0][OP_W-1:0] pp;  // pp[i][j] = a_i & b_j
  logic [PROD_W-1:0] prod_d, prod_q;

  // Row sums r*_s[k] and carries r*_c[k], bit k of each row
  logic [OP_W-1:0] r1_s, r1_c, r2_s, r2_c, r3_s, r3_c;

  assign a_vec = {a3, a2, a1, a0};
  assign b_vec = {b3, b2, b1, b0};

  always_comb begin
    pp = '0;
    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        pp[i][j] = a_vec[i] & b_vec[j];
      end
    end
  end

  // Row 1: pp[*][1] plus pp[*][0] shifted down by one
  assign r1_s[0] = pp[0][1] ^ pp[1][0];
  assign r1_c[0] = pp[0][1] & pp[1][0];
  full_adder u_fa_r1_1 (.a(pp[1][1]), .b(pp[2][0]), .cin(r1_c[0]), .sum(r1_s[1]), .cout(r1_c[1]));
  full_adder u_fa_r1_2 (.a(pp[2][1]), .b(pp[3][0]), .cin(r1_c[1]), .sum(r1_s[2]), .cout(r1_c[2]));
  assign r1_s[3] = pp[3][1] ^ r1_c[2];
  assign r1_c[3] = pp[3][1] & r1_c[2];

  // Row 2: running sum is {r1_c[3], r1_s[3:1]}
  assign r2_s[0] = pp[0][2] ^ r1_s[1];
  assign r2_c[0] = pp[0][2] & r1_s[1];
  full_adder u_fa_r2_1 (.a(pp[1][2]), .b(r1_s[2]), .cin(r2_c[0]), .sum(r2_s[1]), .cout(r2_c[1]));
  full_adder u_fa_r2_2 (.a(pp[2][2]), .b(r1_s[3]), .cin(r2_c[1]), .sum(r2_s[2]), .cout(r2_c[2]));
  full_adder u_fa_r2_3 (.a(pp[3][2]), .b(r1_c[3]), .cin(r2_c[2]), .sum(r2_s[3]), .cout(r2_c[3]));

  // Row 3: running sum is {r2_c[3], r2_s[3:1]}
  assign r3_s[0] = pp[0][3] ^ r2_s[1];
  assign r3_c[0] = pp[0][3] & r2_s[1];
  full_adder u_fa_r3_1 (.a(pp[1][3]), .b(r2_s[2]), .cin(r3_c[0]), .sum(r3_s[1]), .cout(r3_c[1]));
  full_adder u_fa_r3_2 (.a(pp[2][3]), .b(r2_s[3]), .cin(r3_c[1]), .sum(r3_s[2]), .cout(r3_c[2]));
  full_adder u_fa_r3_3 (.a(pp[3][3]), .b(r2_c[3]), .cin(r3_c[2]), .sum(r3_s[3]), .cout(r3_c[3]));

  assign prod_d = {r3_c[3], r3_s[3:0], r2_s[0], r1_s[0], pp[0][0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= PROD_RST;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign {p7, p6, p5, p4, p3, p2, p1, p0} = prod_q;
endmodule

// File: tb/tb_multiplier_4x4.sv
// Self-checking bench for multiplier_4x4 against plain integer multiplication.
module tb_multiplier_4x4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic p0, p1, p2, p3, p4, p5, p6, p7;
  logic [7:0] p;
  int checks = 0;
  int failures = 0;

  assign p = {p7, p6, p5, p4, p3, p2, p1, p0};

  always #5 clk = ~clk;

  multiplier_4x4 dut (
    .clk(clk), .rst_n(rst_n),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
    .b0(b[0]), .b1(b[1]), .b2(b[2]), .b3(b[3]),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7)
  );

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    int prod;
    prod = int'(x) * int'(y);
    return prod[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] expected);
    checks++;
    assert (p === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, p, expected);
    end
  endtask

  // Drive operands just after an edge, then sample 1 time unit after the next edge.
  task automatic apply(input logic [3:0] x, input logic [3:0] y);
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ca [5] = '{4'd15, 4'd0, 4'd1, 4'd8, 4'd12};
  logic [3:0] cb [5] = '{4'd15, 4'd15, 4'd9, 4'd8, 4'd10};
  logic [7:0] cp [5] = '{8'hE1, 8'h00, 8'h09, 8'h40, 8'h78};

  initial begin
    #1 rst_n = 1'b0;
    #1 check("reset_idle", 8'h00);
    apply(4'd15, 4'd15);
    check("reset_held_over_edge", 8'h00);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = i[7:0];
      apply(v[7:4], v[3:0]);
      check("sweep", ref_mul(v[7:4], v[3:0]));
    end

    for (int k = 0; k < 5; k++) begin
      apply(ca[k], cb[k]);
      check("corner", cp[k]);
    end

    for (int k = 0; k < 200; k++) begin
      logic [3:0] x, y;
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      apply(x, y);
      check("random", ref_mul(x, y));
    end

    apply(4'd15, 4'd15);
    check("pre_reset_e1", 8'hE1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_cycle", 8'h00);
    @(posedge clk);
    #1 check("reset_discards_inflight", 8'h00);
    #2 rst_n = 1'b1;
    a = 4'd3;
    b = 4'd5;
    @(posedge clk);
    #1 check("first_after_release", 8'h0F);

    apply(4'd7, 4'd9);
    check("latency_base", 8'd63);
    #2 a = 4'd2;
    b = 4'd6;
    #1 check("latency_hold_between_edges", 8'd63);
    @(posedge clk);
    #1 check("latency_update", 8'd12);
    @(posedge clk);
    #1 check("latency_stable", 8'd12);

    apply(4'd15, 4'd15);
    check("b2b_e1", 8'hE1);
    apply(4'd0, 4'd0);
    check("b2b_00", 8'h00);
    apply(4'd15, 4'd1);
    check("b2b_0f", 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multiplier_4x4.md
# multiplier_4x4

Unsigned 4-bit × 4-bit array multiplier with a registered 8-bit product. Operands and product are exposed as individual bit ports. It serves as the small arithmetic leaf block of the VLSI datapath project, and its gate-level array structure is the object of study. The combinational core is a classic AND-gate and adder array, followed by one output register stage.

## Interface
- Parameters: none. Operand width is fixed at 4 and product width at 8.
- clk  input  1  rising-edge clock; one clock domain only.
- rst_n  input  1  asynchronous, active-low reset.
- a0, a1, a2, a3  input  1 each  operand A; a0 is the LSB and a3 is the MSB.
- b0, b1, b2, b3  input  1 each  operand B; b0 is the LSB and b3 is the MSB.
- p0 … p7  output  1 each  product P; p0 is the LSB and p7 is the MSB.
- Port order is fixed: clk, rst_n, a0, a1, a2, a3, b0, b1, b2, b3, p0 … p7.

## Operation
- Computes P = A × B, unsigned, with A = {a3,a2,a1,a0} and B = {b3,b2,b1,b0}.
- The result is exact over all 256 input pairs; the maximum is 15 × 15 = 225 = 8'b1110_0001, so there is no overflow or truncation.
- Partial products: 16 two-input ANDs, pp[i][j] = a_i & b_j.
- Reduction: a carry-propagate array of 4 half adders and 8 full adders, in rows j = 1..3.
  - Row j adds pp[*][j] to the shifted running sum from row j−1.
- Bit p0 = pp[0][0], taken directly. Bits p1 … p3 are the LSB output of each row. Bits p4 … p7 are the sum and carry outputs of the final row.
- The 8-bit combinational result is captured into the output register on every rising edge of clk.
- There is no enable and no handshake; inputs are sampled every cycle.
- No X-propagation special handling is required; inputs are assumed to be 0 or 1 at the sampling edge.

## Timing
- Latency is 1 cycle: inputs stable before rising edge k appear on p0 … p7 after edge k, and stay there until edge k+1.
- Throughput is 1 product per cycle, with no stalls.
- Reset: when rst_n is low, p0 … p7 go to 0 immediately, without waiting for clk.
- Reset mid-operation discards the in-flight product.
- After rst_n is released, the first valid product is the one sampled at the first rising edge with rst_n high.
- Inputs changing between edges have no effect on the outputs.
- The combinational array (roughly 7 adder delays on the critical path, through the row carries into p7) must settle within one clock period.

## Structure
- Shared package `mult_pkg` holds:
  - constant `OP_W = 4`;
  - constant `PROD_W = 8`;
  - the reset value `PROD_RST = 8'h00`.
- Sub-module `full_adder` (a, b, cin → sum, cout), instantiated 8 times.
- Half adders are plain XOR/AND expressions inline.
- The top level contains the AND array, the adder rows, and one `always` block with async reset for the 8-bit product register.

## Test plan
- Exhaustive sweep: drive {a3..a0, b3..b0} = i for i = 0..255, holding each value for one clock. Expected: one cycle later, {p7..p0} == (i>>4)*(i&15) for every i.
- Corners:
  - A=15, B=15 → P=8'hE1.
  - A=0, B=15 → 8'h00.
  - A=1, B=9 → 8'h09.
  - A=8, B=8 → 8'h40.
  - A=12, B=10 → 8'h78.
- Async reset: with P=8'hE1 held, pull rst_n low mid-cycle. Expected: P=0 before the next edge. Release, apply A=3, B=5; expected: P=8'h0F after the next edge.
- Latency check: change A/B between edges. Expected: P holds its previous value until the rising edge, then updates exactly once.
- Back-to-back operands: A=15,B=15 then A=0,B=0 then A=15,B=1 on consecutive edges. Expected outputs: E1, 00, 0F in consecutive cycles.
